// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt block: state encoding,
// default message length and the ASCII bounds of a legal plaintext byte.
package rc4_pkg;

  localparam int unsigned MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;  // 'a'
  localparam logic [7:0] CHAR_HI    = 8'h7A;  // 'z'
  localparam logic [7:0] CHAR_SPACE = 8'h20;  // ' '

  // One byte walks RD_SI .. NEXT, ten states in all.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_WR_D,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Flags a decrypted byte as legal when it is a lowercase letter or a space.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] ch,
  output logic       legal
);

  // Pure range/equality test on the byte.
  assign legal = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ch == CHAR_SPACE);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over a pre-scheduled S array: generates one keystream byte per
// message byte, XORs it with the encrypted ROM and writes the plaintext.
// All memory-facing outputs are registered: whatever a state assigns becomes
// visible on the port during the following cycle, and the synchronous memory
// returns its data one cycle after that.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       done,
  output logic       msg_valid,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [4:0] d_address,
  output logic [7:0] d_data,
  output logic       d_wren
);

  localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] i;
  logic [7:0] j;
  logic [4:0] k;
  logic [7:0] si;
  logic [7:0] sj;
  logic       valid;
  logic [7:0] plain;
  logic       legal;

  // Keystream byte arrives on s_q while rom_q holds the ciphertext byte.
  assign plain = s_q ^ rom_q;

  rc4_char_check u_char_check (
    .ch    (plain),
    .legal (legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: a fixed ten-state walk per byte, start honoured only
  // while parked in IDLE or DONE.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE:    if (start) state_next = ST_RD_SI;
      ST_RD_SI:   state_next = ST_WAIT_SI;
      ST_WAIT_SI: state_next = ST_RD_SJ;
      ST_RD_SJ:   state_next = ST_WAIT_SJ;
      ST_WAIT_SJ: state_next = ST_WR_SI;
      ST_WR_SI:   state_next = ST_WR_SJ;
      ST_WR_SJ:   state_next = ST_RD_F;
      ST_RD_F:    state_next = ST_WAIT_F;
      ST_WAIT_F:  state_next = ST_WR_D;
      ST_WR_D:    state_next = ST_NEXT;
      ST_NEXT:    state_next = (k == K_LAST) ? ST_DONE : ST_RD_SI;
      ST_DONE:    if (start) state_next = ST_RD_SI;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered memory ports; write enables are single-cycle
  // pulses, so they fall back to zero unless the current state raises them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      valid       <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      d_address   <= '0;
      d_data      <= '0;
      d_wren      <= 1'b0;
      done        <= 1'b0;
      msg_valid   <= 1'b0;
    end else begin
      s_wren    <= 1'b0;
      d_wren    <= 1'b0;
      done      <= (state_next == ST_DONE);
      msg_valid <= (state_next == ST_DONE) && valid;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            valid <= 1'b1;
          end
        end
        ST_RD_SI: begin
          i         <= i + 8'd1;
          s_address <= i + 8'd1;
        end
        ST_RD_SJ: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
        end
        ST_WR_SI: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
        end
        ST_WR_SJ: begin
          // When i == j both writes target one address with the same value,
          // and this later write is the one that lands last.
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
        end
        ST_RD_F: begin
          s_address   <= si + sj;
          rom_address <= k;
        end
        ST_WR_D: begin
          d_address <= k;
          d_data    <= plain;
          d_wren    <= 1'b1;
          if (!legal) valid <= 1'b0;
        end
        ST_NEXT: begin
          if (k != K_LAST) k <= k + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: behavioural memories around the
// DUT and a plain RC4 PRGA reference model operating on arrays.
module tb_rc4_prga_decrypt;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       done;
  logic       msg_valid;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [4:0] rom_address;
  logic [7:0] rom_q;
  logic [4:0] d_address;
  logic [7:0] d_data;
  logic       d_wren;

  rc4_prga_decrypt #(.MSG_LEN(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .done        (done),
    .msg_valid   (msg_valid),
    .s_address   (s_address),
    .s_data      (s_data),
    .s_wren      (s_wren),
    .s_q         (s_q),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .d_address   (d_address),
    .d_data      (d_data),
    .d_wren      (d_wren)
  );

  always #5 clk = ~clk;

  // Memories and write counters.
  logic [7:0] s_mem   [256];
  logic [7:0] rom_mem [N];
  logic [7:0] d_mem   [N];
  int         s_writes = 0;
  int         d_writes = 0;
  int         dual_writes = 0;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
    if (s_wren) begin
      s_mem[s_address] = s_data;
      s_writes = s_writes + 1;
    end
    if (d_wren) begin
      d_mem[d_address] = d_data;
      d_writes = d_writes + 1;
    end
    if (s_wren && d_wren) dual_writes = dual_writes + 1;
  end

  // Reference model state.
  logic [7:0] s_init [256];
  logic [7:0] m_s    [256];
  logic [7:0] m_dec  [N];
  logic       m_valid;

  int n_vec = 0;
  int n_err = 0;
  int sw0;
  int dw0;
  int cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

  // RC4 PRGA from i=j=0 over m_s, decrypting the first nbytes of the ROM.
  task automatic model_run(input int nbytes);
    int         mi;
    int         mj;
    logic [7:0] t;
    mi = 0;
    mj = 0;
    m_valid = 1'b1;
    for (int kk = 0; kk < nbytes; kk++) begin
      mi = (mi + 1) % 256;
      mj = (mj + m_s[mi]) % 256;
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      m_dec[kk] = rom_mem[kk] ^ m_s[(m_s[mi] + m_s[mj]) % 256];
      if (!is_legal(m_dec[kk])) m_valid = 1'b0;
    end
  endtask

  // Standard RC4 key schedule with a random 3-byte key.
  task automatic ksa();
    logic [7:0] key [3];
    logic [7:0] t;
    int         kj;
    for (int n = 0; n < 3; n++) key[n] = 8'($urandom);
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    kj = 0;
    for (int n = 0; n < 256; n++) begin
      kj = (kj + s_init[n] + key[n % 3]) % 256;
      t = s_init[n];
      s_init[n] = s_init[kj];
      s_init[kj] = t;
    end
  endtask

  task automatic load_s();
    for (int n = 0; n < 256; n++) begin
      s_mem[n] = s_init[n];
      m_s[n]   = s_init[n];
    end
  endtask

  // ROM whose plaintext is legal text, except byte bad_idx decrypts to 0x41.
  task automatic make_text_rom(input int bad_idx);
    int r;
    for (int n = 0; n < N; n++) rom_mem[n] = 8'h00;
    for (int n = 0; n < 256; n++) m_s[n] = s_init[n];
    model_run(N);
    for (int n = 0; n < N; n++) begin
      r = $urandom_range(0, 26);
      if (n == bad_idx)  rom_mem[n] = m_dec[n] ^ 8'h41;
      else if (r == 26)  rom_mem[n] = m_dec[n] ^ 8'h20;
      else               rom_mem[n] = m_dec[n] ^ (8'h61 + 8'(r));
    end
  endtask

  task automatic do_run(input int pulse_cyc);
    @(negedge clk) start = 1'b1;
    sw0 = s_writes;
    dw0 = d_writes;
    @(posedge clk);
    cycles = 0;
    @(negedge clk) start = 1'b0;
    check("done_low_after_start", {31'd0, done}, 32'd0);
    while (!done && cycles < 1000) begin
      check("msg_valid_outside_done", {31'd0, msg_valid}, 32'd0);
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = (cycles == pulse_cyc);
    end
    start = 1'b0;
    check("run_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_result(input string tag);
    for (int n = 0; n < N; n++)
      check($sformatf("%s dec[%0d]", tag, n), {24'd0, d_mem[n]}, {24'd0, m_dec[n]});
    for (int n = 0; n < 256; n++)
      check($sformatf("%s S[%0d]", tag, n), {24'd0, s_mem[n]}, {24'd0, m_s[n]});
    check({tag, " msg_valid"}, {31'd0, msg_valid}, {31'd0, m_valid});
    check({tag, " cycles"}, cycles, 10 * N);
    check({tag, " s_writes"}, s_writes - sw0, 2 * N);
    check({tag, " d_writes"}, d_writes - dw0, N);
    check({tag, " dual_writes"}, dual_writes, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    for (int n = 0; n < N; n++) begin
      rom_mem[n] = 8'h00;
      d_mem[n]   = 8'h00;
    end
    for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst msg_valid", {31'd0, msg_valid}, 32'd0);
    check("rst s_wren", {31'd0, s_wren}, 32'd0);
    check("rst d_wren", {31'd0, d_wren}, 32'd0);
    check("rst s_address", {24'd0, s_address}, 32'd0);
    check("rst s_data", {24'd0, s_data}, 32'd0);
    check("rst rom_address", {27'd0, rom_address}, 32'd0);
    check("rst d_address", {27'd0, d_address}, 32'd0);
    check("rst d_data", {24'd0, d_data}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity S with a hand-computed first two bytes.
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < N; n++) rom_mem[n] = 8'($urandom);
    rom_mem[0] = 8'h63;
    rom_mem[1] = 8'h66;
    load_s();
    model_run(N);
    do_run(-1);
    check("ident dec0", {24'd0, d_mem[0]}, 32'h61);
    check("ident dec1", {24'd0, d_mem[1]}, 32'h63);
    check_result("ident");

    // Key-scheduled S, legal text; restarted straight from DONE.
    ksa();
    make_text_rom(-1);
    load_s();
    model_run(N);
    do_run(-1);
    check("text msg_valid", {31'd0, msg_valid}, 32'd1);
    check_result("text");

    // One byte decrypting to 'A' clears msg_valid; every byte still written.
    ksa();
    make_text_rom($urandom_range(0, N - 1));
    for (int n = 0; n < N; n++) d_mem[n] = 8'h00;
    load_s();
    model_run(N);
    do_run(-1);
    check("bad msg_valid", {31'd0, msg_valid}, 32'd0);
    check_result("bad");

    // i == j on byte 0 (S[1]=1) and the j wrap case (S[1]=0xFF).
    for (int v = 0; v < 2; v++) begin
      logic [7:0] want;
      logic [7:0] t;
      want = (v == 0) ? 8'h01 : 8'hFF;
      ksa();
      for (int n = 0; n < 256; n++) begin
        if (s_init[n] == want) begin
          t = s_init[1];
          s_init[1] = s_init[n];
          s_init[n] = t;
        end
      end
      for (int n = 0; n < N; n++) rom_mem[n] = 8'($urandom);
      load_s();
      model_run(N);
      do_run(-1);
      check_result((v == 0) ? "ieqj" : "jwrap");
    end

    // Reset asserted during WR_SI of byte 5.
    ksa();
    for (int n = 0; n < N; n++) rom_mem[n] = 8'($urandom);
    load_s();
    model_run(5);
    @(negedge clk) start = 1'b1;
    sw0 = s_writes;
    dw0 = d_writes;
    @(posedge clk);
    cycles = 0;
    @(negedge clk) start = 1'b0;
    while (cycles < 54) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check("midrst s_wren", {31'd0, s_wren}, 32'd0);
    check("midrst d_wren", {31'd0, d_wren}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    repeat (5) @(negedge clk);
    check("midrst s_writes", s_writes - sw0, 10);
    check("midrst d_writes", d_writes - dw0, 5);
    for (int n = 0; n < 256; n++)
      check($sformatf("midrst S[%0d]", n), {24'd0, s_mem[n]}, {24'd0, m_s[n]});
    for (int n = 0; n < 5; n++)
      check($sformatf("midrst dec[%0d]", n), {24'd0, d_mem[n]}, {24'd0, m_dec[n]});
    model_run(N);
    do_run(-1);
    check_result("after_rst");

    // Start pulse during byte 3 changes nothing.
    ksa();
    make_text_rom(-1);
    load_s();
    model_run(N);
    do_run(33);
    check("pulse msg_valid", {31'd0, msg_valid}, 32'd1);
    check_result("pulse");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
